// File: rtl/cone_sweep_pkg.sv
// Shared types and helpers for the cone sweep controller.
// Holds default widths, the FSM state encoding and the x_out composition rule.
package cone_sweep_pkg;

    localparam int N_IN_DEF  = 13;
    localparam int CNT_W_DEF = N_IN_DEF + 1;
    localparam int MAX_IN    = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Free inputs come from the enumeration counter, fixed inputs from the latched values.
    function automatic logic [MAX_IN-1:0] compose_x(
        input logic [MAX_IN-1:0] f,
        input logic [MAX_IN-1:0] mask,
        input logic [MAX_IN-1:0] val
    );
        return (f & ~mask) | (val & mask);
    endfunction

endpackage

// File: rtl/sweep_masked_incr.sv
// Masked increment: steps the free-input counter over the zero bits of mask only.
// Combinational; last flags the carry out of the top bit, i.e. the final vector.
module sweep_masked_incr #(
    parameter int N = 13
) (
    input  logic [N-1:0] f,
    input  logic [N-1:0] mask,
    output logic [N-1:0] next_f,
    output logic         last
);

    logic [N:0] sum;

    // Forcing fixed bits to 1 lets the carry ripple straight through them.
    assign sum    = {1'b0, f | mask} + (N+1)'(1);
    assign next_f = sum[N-1:0] & ~mask;
    assign last   = sum[N];

endmodule

// File: rtl/cone_sweep_ctrl.sv
// Sweeps a combinational cone over every vector of a restriction, counting ON-set minterms
// and capturing the lowest ON vector; a LAT-deep tag pipe aligns samples with cone latency.
module cone_sweep_ctrl
    import cone_sweep_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int LAT   = 0,
    parameter int CNT_W = N_IN + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [N_IN-1:0]  fix_mask,
    input  logic [N_IN-1:0]  fix_val,
    input  logic             y_in,
    output logic [N_IN-1:0]  x_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] onset_cnt,
    output logic [N_IN-1:0]  first_on,
    output logic             first_on_vld
);

    localparam logic [1:0] LAT_M1 = 2'(LAT > 0 ? LAT - 1 : 0);

    state_t          state;
    state_t          state_nxt;
    logic [N_IN-1:0] mask_q;
    logic [N_IN-1:0] val_q;
    logic [N_IN-1:0] f_q;
    logic            all_issued;
    logic            iss_q;
    logic [1:0]      drain_cnt;

    logic            accept;
    logic            issue;
    logic            load_vec;
    logic            flush;
    logic            sample;
    logic [N_IN-1:0] inc_f;
    logic [N_IN-1:0] inc_mask;
    logic [N_IN-1:0] inc_val;
    logic [N_IN-1:0] next_f;
    logic            last;
    logic [N_IN-1:0] x_nxt;
    logic            tap_vld;
    logic [N_IN-1:0] tap_vec;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SWEEP;
                end
            end
            SWEEP: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (all_issued) begin
                    state_nxt = (LAT == 0) ? DONE : DRAIN;
                end else begin
                    issue = 1'b1;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (drain_cnt == LAT_M1) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SWEEP;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy     = (state == SWEEP) || (state == DRAIN);
    assign done     = (state == DONE);
    assign load_vec = accept | issue;
    assign flush    = busy & abort;

    // Vector 0 is issued on the accepting edge itself, straight from the live inputs.
    assign inc_f    = accept ? '0 : f_q;
    assign inc_mask = accept ? fix_mask : mask_q;
    assign inc_val  = accept ? fix_val : val_q;
    assign x_nxt    = N_IN'(compose_x(MAX_IN'(inc_f), MAX_IN'(inc_mask), MAX_IN'(inc_val)));

    sweep_masked_incr #(
        .N(N_IN)
    ) u_incr (
        .f      (inc_f),
        .mask   (inc_mask),
        .next_f (next_f),
        .last   (last)
    );

    generate
        if (LAT == 0) begin : g_direct
            assign tap_vld = iss_q;
            assign tap_vec = x_out;
        end else begin : g_pipe
            logic [LAT-1:0]  vld_pipe;
            logic [N_IN-1:0] vec_pipe [LAT];

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    vld_pipe <= '0;
                end else begin
                    vld_pipe[0] <= iss_q;
                    for (int i = 1; i < LAT; i++) begin
                        vld_pipe[i] <= vld_pipe[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                vec_pipe[0] <= x_out;
                for (int i = 1; i < LAT; i++) begin
                    vec_pipe[i] <= vec_pipe[i-1];
                end
            end

            assign tap_vld = vld_pipe[LAT-1];
            assign tap_vec = vec_pipe[LAT-1];
        end
    endgenerate

    assign sample = tap_vld & y_in & busy & ~abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            mask_q       <= '0;
            val_q        <= '0;
            f_q          <= '0;
            all_issued   <= 1'b0;
            iss_q        <= 1'b0;
            drain_cnt    <= '0;
            x_out        <= '0;
            onset_cnt    <= '0;
            first_on     <= '0;
            first_on_vld <= 1'b0;
        end else begin
            state <= state_nxt;
            iss_q <= load_vec;
            if (load_vec) begin
                x_out      <= x_nxt;
                f_q        <= next_f;
                all_issued <= last;
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            if (accept) begin
                mask_q       <= fix_mask;
                val_q        <= fix_val;
                onset_cnt    <= '0;
                first_on     <= '0;
                first_on_vld <= 1'b0;
            end else if (sample) begin
                onset_cnt <= onset_cnt + CNT_W'(1);
                // Enumeration is increasing, so the first ON sample is the minimum.
                if (!first_on_vld) begin
                    first_on     <= tap_vec;
                    first_on_vld <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cone_sweep_ctrl.sv
// Scoreboard bench: two controllers (LAT=0 and LAT=2) share stimulus, each drives its own cone model.
// Expected results are queued at start; a negedge monitor checks them when done pulses.
module tb_cone_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [12:0] fix_mask;
    logic [12:0] fix_val;

    logic        y0, y2;
    logic [12:0] x0, x2;
    logic        busy0, busy2, done0, done2, vld0, vld2;
    logic [13:0] cnt0, cnt2;
    logic [12:0] fo0, fo2;
    logic [12:0] x2_d1, x2_d2;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [13:0] cnt;
        logic [12:0] fo;
        logic        vld;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cone_sweep_ctrl #(.N_IN(13), .LAT(0), .CNT_W(14)) u0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .fix_mask(fix_mask), .fix_val(fix_val), .y_in(y0),
        .x_out(x0), .busy(busy0), .done(done0), .onset_cnt(cnt0),
        .first_on(fo0), .first_on_vld(vld0)
    );

    cone_sweep_ctrl #(.N_IN(13), .LAT(2), .CNT_W(14)) u2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .fix_mask(fix_mask), .fix_val(fix_val), .y_in(y2),
        .x_out(x2), .busy(busy2), .done(done2), .onset_cnt(cnt2),
        .first_on(fo2), .first_on_vld(vld2)
    );

    function automatic logic cone(input logic [12:0] x);
        return (x[3:0] == 4'd0) && !x[7] && x[4] && x[5] && x[6] && x[8] &&
               ((x[9] & x[10]) | (x[11] & x[12]));
    endfunction

    assign y0 = cone(x0);
    always @(posedge clk) begin
        x2_d1 <= x2;
        x2_d2 <= x2_d1;
    end
    assign y2 = cone(x2_d2);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_res(input string nm, input exp_t e, input logic [13:0] cnt,
                           input logic [12:0] fo, input logic vld, input logic busy);
        chk({nm, ".done_cycle"}, 32'(cyc), 32'(e.cyc));
        chk({nm, ".onset_cnt"}, 32'(cnt), 32'(e.cnt));
        chk({nm, ".first_on"}, 32'(fo), 32'(e.fo));
        chk({nm, ".first_on_vld"}, 32'(vld), 32'(e.vld));
        chk({nm, ".busy_at_done"}, 32'(busy), 32'd0);
    endtask

    always @(negedge clk) begin
        if (done0) begin
            if (q0.size() == 0) begin
                chk("lat0.unexpected_done", 32'd1, 32'd0);
            end else begin
                chk_res("lat0", q0.pop_front(), cnt0, fo0, vld0, busy0);
            end
        end
        if (done2) begin
            if (q2.size() == 0) begin
                chk("lat2.unexpected_done", 32'd1, 32'd0);
            end else begin
                chk_res("lat2", q2.pop_front(), cnt2, fo2, vld2, busy2);
            end
        end
    end

    task automatic pulse_start(input logic [12:0] m, input logic [12:0] v);
        @(negedge clk);
        fix_mask = m;
        fix_val  = v;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue(input logic [12:0] m, input logic [12:0] v,
                         input logic [13:0] cnt, input logic [12:0] fo, input logic vld);
        int nv;
        nv = 1 << $countones(~m);
        @(negedge clk);
        fix_mask = m;
        fix_val  = v;
        start    = 1'b1;
        q0.push_back('{cnt, fo, vld, cyc + 1 + nv});
        q2.push_back('{cnt, fo, vld, cyc + 1 + nv + 2});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q0.size() != 0 || q2.size() != 0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) begin
            chk("wait_done_timeout", 32'd1, 32'd0);
            q0.delete();
            q2.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, ".x_out"}, 32'({x0, x2}), 32'd0);
        chk({nm, ".busy"}, 32'({busy0, busy2}), 32'd0);
        chk({nm, ".done"}, 32'({done0, done2}), 32'd0);
        chk({nm, ".onset_cnt"}, 32'({cnt0, cnt2}), 32'd0);
        chk({nm, ".first_on"}, 32'({fo0, fo2}), 32'd0);
        chk({nm, ".first_on_vld"}, 32'({vld0, vld2}), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        fix_mask = '0;
        fix_val  = '0;
        repeat (2) @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b0;

        // Full 8192-vector sweep, then results must hold after done.
        issue(13'h0000, 13'h0000, 14'd7, 13'h0770, 1'b1);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("hold.onset_cnt", 32'({cnt0, cnt2}), 32'({14'd7, 14'd7}));
        chk("hold.first_on", 32'({fo0, fo2}), 32'({13'h0770, 13'h0770}));

        issue(13'h01FF, 13'h0170, 14'd7, 13'h0770, 1'b1);
        wait_idle();
        issue(13'h01FF, 13'h0171, 14'd0, 13'h0000, 1'b0);
        wait_idle();
        issue(13'h1FFF, 13'h0770, 14'd1, 13'h0770, 1'b1);
        wait_idle();

        // Abort after five SWEEP cycles: idle next cycle, no done.
        pulse_start(13'h01FF, 13'h0170);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort.busy", 32'({busy0, busy2}), 32'd0);
        chk("abort.done", 32'({done0, done2}), 32'd0);
        repeat (3) @(negedge clk);
        chk("abort.still_idle", 32'({busy0, busy2}), 32'd0);
        issue(13'h01FF, 13'h0170, 14'd7, 13'h0770, 1'b1);
        wait_idle();

        // Reset mid-sweep returns everything to reset values.
        pulse_start(13'h0000, 13'h0000);
        repeat (20) @(negedge clk);
        chk("midsweep.busy", 32'({busy0, busy2}), 32'h3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state("midsweep_rst");

        // start and new restriction while busy must not disturb the running sweep.
        issue(13'h01FF, 13'h0170, 14'd7, 13'h0770, 1'b1);
        repeat (4) @(negedge clk);
        fix_mask = 13'h1FFF;
        fix_val  = 13'h0000;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
